// File: rtl/mux8_arb_pkg.sv
// Shared sizes, state encoding and helpers for the 8-source round-robin mux arbiter.
package mux8_arb_pkg;

  localparam int N     = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping 7 -> 0.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [SEL_W-1:0] off;

  always_comb begin
    dbl   = {req, req};
    // rot[k] corresponds to source (ptr + k) mod N
    rot   = dbl[{1'b0, ptr} +: N];
    found = |rot;
    off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = SEL_W'(k);
    end
    idx   = ptr + off;
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select of the 8-to-1 bus mux, with bounded tenure.
//   state | meaning
//   IDLE  | no grant active; any request is granted on the next edge
//   GRANT | owner holds the bus until it drops req or uses MAX_HOLD cycles
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] cline,
  output logic             busy
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t           state, state_n;
  logic [SEL_W-1:0] owner, owner_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [3:0]       hold_cnt, hold_n;
  logic [N-1:0]     gnt_n;
  logic [SEL_W-1:0] cline_n;
  logic             busy_n;

  logic             release_now;
  logic [SEL_W-1:0] pick_ptr;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;

  // On release the former owner drops to lowest priority for the same-edge handoff
  always_comb begin
    release_now = (state == GRANT) && (!req[owner] || (hold_cnt == HOLD_LAST));
    pick_ptr    = release_now ? owner + SEL_W'(1) : ptr;
  end

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    gnt_n   = gnt;
    cline_n = cline;
    busy_n  = busy;

    if (state == GRANT && !release_now) begin
      hold_n = hold_cnt + 4'd1;
    end else begin
      if (release_now) ptr_n = pick_ptr;
      if (pick_found) begin
        state_n = GRANT;
        owner_n = pick_idx;
        hold_n  = '0;
        gnt_n   = onehot(pick_idx);
        cline_n = pick_idx;
        busy_n  = 1'b1;
      end else begin
        state_n = IDLE;
        hold_n  = '0;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      cline    <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      gnt      <= gnt_n;
      cline    <= cline_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: directed request patterns with hand-derived grants.
module tb_mux8_rr_arbiter;
  import mux8_arb_pkg::*;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req   = '0;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] cline;
  logic             busy;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .cline (cline),
    .busy  (busy)
  );

  typedef struct {
    int          stamp;
    logic [7:0]  g;
    logic [2:0]  c;
    logic        b;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  event sample_ev;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation that is due and checks structural invariants
  initial begin
    forever begin
      @(negedge clk or sample_ev);
      while (sb.size() > 0 && sb[0].stamp <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if ({gnt, cline, busy} !== {e.g, e.c, e.b}) begin
          n_bad++;
          $display("FAIL %s cyc=%0d: got gnt=%h cline=%0d busy=%b, want gnt=%h cline=%0d busy=%b",
                   e.tag, cyc, gnt, cline, busy, e.g, e.c, e.b);
        end
      end
      n_cmp++;
      if ($countones(gnt) > 1 || gnt[cline] !== busy) begin
        n_bad++;
        $display("FAIL invariant cyc=%0d: got gnt=%h cline=%0d busy=%b, want one-hot gnt with gnt[cline]==busy",
                 cyc, gnt, cline, busy);
      end
    end
  end

  task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] eg,
                      input logic [2:0] ec, input logic eb, input string tag);
    @(negedge clk);
    #1;
    rst_n = r;
    req   = rq;
    sb.push_back('{cyc + 1, eg, ec, eb, tag});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    rst_n = 1'b0;
    req   = 8'hFF;

    // reset held with every source requesting, then full-load rotation
    step(1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, "rst_hold");
    step(1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, "rst_hold");
    for (int k = 1; k <= 36; k++) begin
      c = ((k - 1) / 4) % 8;
      step(1'b1, 8'hFF, 8'(8'd1 << c), 3'(c), 1'b1, (k == 1) ? "rst_release" : "full_load");
    end

    // two requesters alternate with zero idle between tenures
    step(1'b0, 8'h24, 8'h00, 3'd0, 1'b0, "rst");
    for (int k = 1; k <= 12; k++) begin
      c = (((k - 1) / 4) % 2 == 0) ? 2 : 5;
      step(1'b1, 8'h24, 8'(8'd1 << c), 3'(c), 1'b1, "pair_2_5");
    end

    // source 7 drops early; pointer wraps to 0
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, "rst");
    step(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "idle");
    step(1'b1, 8'h80, 8'h80, 3'd7, 1'b1, "src7");
    step(1'b1, 8'h80, 8'h80, 3'd7, 1'b1, "src7");
    step(1'b1, 8'h00, 8'h00, 3'd7, 1'b0, "drop7");
    step(1'b1, 8'h00, 8'h00, 3'd7, 1'b0, "drop7_idle");
    step(1'b1, 8'h01, 8'h01, 3'd0, 1'b1, "wrap0");

    // sole requester re-granted after each expiry without a gap
    step(1'b0, 8'h08, 8'h00, 3'd0, 1'b0, "rst");
    for (int k = 1; k <= 10; k++) step(1'b1, 8'h08, 8'h08, 3'd3, 1'b1, "sole3");
    step(1'b1, 8'h00, 8'h00, 3'd3, 1'b0, "sole3_drop");

    // ptr now 4: scan 4..7,0.. picks 2 before 3; then handoff on drop
    step(1'b1, 8'h0C, 8'h04, 3'd2, 1'b1, "rr_from4");
    step(1'b1, 8'h08, 8'h08, 3'd3, 1'b1, "handoff3");
    step(1'b1, 8'h00, 8'h00, 3'd3, 1'b0, "idle3");

    // asynchronous reset mid-tenure while source 5 owns the bus
    step(1'b0, 8'h20, 8'h00, 3'd0, 1'b0, "rst");
    step(1'b1, 8'h20, 8'h20, 3'd5, 1'b1, "pre_rst5");
    step(1'b1, 8'h20, 8'h20, 3'd5, 1'b1, "pre_rst5");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back('{cyc, 8'h00, 3'd0, 1'b0, "async_rst"});
    -> sample_ev;
    #1;
    rst_n = 1'b1;
    req   = 8'h21;
    sb.push_back('{cyc + 1, 8'h01, 3'd0, 1'b1, "post_rst_ptr0"});
    for (int k = 1; k <= 3; k++) step(1'b1, 8'h21, 8'h01, 3'd0, 1'b1, "post_rst_hold");
    step(1'b1, 8'h21, 8'h20, 3'd5, 1'b1, "rot5");
    step(1'b1, 8'h00, 8'h00, 3'd5, 1'b0, "final_idle");

    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
